// File: rtl/mem_responder.sv
// Wait-stated memory responder for the rv32i multicycle core: word RAM plus a 16-byte MMIO window.
// Optional byte-lane write strobes (mem_strb port) are enabled by defining MEM_RESPONDER_BYTE_STRB_EN.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hF000_0000,
  parameter int unsigned GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wr_data,
  input  logic              mem_wr_ena,
`ifdef MEM_RESPONDER_BYTE_STRB_EN
  input  logic [3:0]        mem_strb,
`endif
  output logic [31:0]       mem_rd_data,
  output logic              mem_ready,
  output logic              mem_err,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WCW       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_wena;
  logic [3:0]         w_strb;
  logic [WCW-1:0]     r_wcnt;
  logic [31:0]        r_cyc;
  logic [GPIO_W-1:0]  r_sync1;
  logic [GPIO_W-1:0]  r_sync2;
  logic [GPIO_W-1:0]  r_gpio_out;
  logic [GPIO_W-1:0]  w_gpio_next;
  logic [31:0]        r_rd_data;
  logic               r_ready;
  logic               r_err;
  logic [31:0]        w_rd_data;
  logic               w_err;
  logic               w_ram_we;
  logic               w_gpio_we;
  logic [AW-1:0]      w_ram_idx;
  logic [31:0]        r_mem [DEPTH_WORDS];

`ifdef MEM_RESPONDER_BYTE_STRB_EN
  logic [3:0] r_strb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_strb <= 4'd0;
    end else if (w_accept) begin
      r_strb <= mem_strb;
    end
  end

  assign w_strb = r_strb;
`else
  assign w_strb = 4'hF;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A request still high during the ready pulse belongs to the finished transaction.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req && !r_ready) begin
          w_accept = 1'b1;
          w_next   = (WAIT_STATES != 0) ? S_WAIT : S_RESP;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_wcnt <= WCW'(1)) begin
          w_next = S_RESP;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wena  <= 1'b0;
      r_wcnt  <= WCW'(0);
    end else if (w_accept) begin
      r_addr  <= mem_addr;
      r_wdata <= mem_wr_data;
      r_wena  <= mem_wr_ena;
      r_wcnt  <= WCW'(WAIT_STATES);
    end else if (r_state == S_WAIT) begin
      r_wcnt <= r_wcnt - WCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc   <= 32'd0;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_cyc   <= r_cyc + 32'd1;
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_rd_data = 32'd0;
    w_err     = 1'b0;
    w_ram_we  = 1'b0;
    w_gpio_we = 1'b0;
    w_ram_idx = r_addr[AW+1:2];
    if (r_addr[1:0] != 2'b00) begin
      w_err = 1'b1;
    end else if (r_addr < RAM_BYTES) begin
      w_rd_data = r_mem[w_ram_idx];
      w_ram_we  = r_wena;
    end else if (r_addr[31:4] == MMIO_BASE[31:4]) begin
      case (r_addr[3:2])
        2'd0: begin
          w_rd_data[GPIO_W-1:0] = r_gpio_out;
          w_gpio_we             = r_wena;
        end
        2'd1:    w_rd_data[GPIO_W-1:0] = r_sync2;
        2'd2:    w_rd_data = r_cyc;
        default: w_rd_data = 32'd0;
      endcase
    end else begin
      w_err = 1'b1;
    end
  end

  // Lane i of the 32-bit write covers gpio bits 8i+7:8i.
  always_comb begin
    w_gpio_next = r_gpio_out;
    for (int b = 0; b < int'(GPIO_W); b++) begin
      if (w_strb[b/8]) begin
        w_gpio_next[b] = r_wdata[b];
      end else begin
        w_gpio_next[b] = r_gpio_out[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_RESP && w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) begin
          r_mem[w_ram_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= 32'd0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_gpio_out <= '0;
    end else if (r_state == S_RESP) begin
      r_ready   <= 1'b1;
      r_err     <= w_err;
      r_rd_data <= r_wena ? 32'd0 : w_rd_data;
      if (w_gpio_we) begin
        r_gpio_out <= w_gpio_next;
      end
    end else begin
      r_ready <= 1'b0;
    end
  end

  assign mem_rd_data = r_rd_data;
  assign mem_ready   = r_ready;
  assign mem_err     = r_err;
  assign gpio_out    = r_gpio_out;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance 0 has WAIT_STATES=1, instance 1 has WAIT_STATES=0.
module tb_mem_responder;

  localparam logic [31:0] MB = 32'hF000_0000;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_d;
    logic        chk_g;
    logic [7:0]  gpio;
    int          lat;
    int          issued;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        wena  [2];
  logic [3:0]  strb  [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic [7:0]  gout  [2];
  logic [7:0]  gin = 8'h00;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   tb_cyc = 0;
  logic [31:0] m_cyc;
  logic prev_ready [2];
  logic prev_rst = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .MMIO_BASE(MB), .GPIO_W(8)) u_ws1 (
    .clk(clk), .rst(rst), .mem_req(req[0]), .mem_addr(addr[0]), .mem_wr_data(wdata[0]),
    .mem_wr_ena(wena[0]),
`ifdef MEM_RESPONDER_BYTE_STRB_EN
    .mem_strb(strb[0]),
`endif
    .mem_rd_data(rdata[0]), .mem_ready(ready[0]), .mem_err(err[0]),
    .gpio_out(gout[0]), .gpio_in(gin)
  );

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .MMIO_BASE(MB), .GPIO_W(8)) u_ws0 (
    .clk(clk), .rst(rst), .mem_req(req[1]), .mem_addr(addr[1]), .mem_wr_data(wdata[1]),
    .mem_wr_ena(wena[1]),
`ifdef MEM_RESPONDER_BYTE_STRB_EN
    .mem_strb(strb[1]),
`endif
    .mem_rd_data(rdata[1]), .mem_ready(ready[1]), .mem_err(err[1]),
    .gpio_out(gout[1]), .gpio_in(gin)
  );

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // Reference cycle counter: cleared by reset, counts every rising edge afterwards.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_cyc <= 32'd0;
    else      m_cyc <= m_cyc + 32'd1;
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h", nm, k, act, exp_v);
    end
  endtask

  // Monitor: reset-release state, then one scoreboard pop per mem_ready pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst && !prev_rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("rst_ready", k, {31'd0, ready[k]}, 32'd0);
        chk("rst_rd_data", k, rdata[k], 32'd0);
        chk("rst_err", k, {31'd0, err[k]}, 32'd0);
        chk("rst_gpio_out", k, {24'd0, gout[k]}, 32'd0);
      end
    end
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        if (ready[k]) begin
          chk("ready_pulse_width", k, {31'd0, prev_ready[k]}, 32'd0);
          if (((k == 0) ? q0.size() : q1.size()) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ready dut%0d: got mem_ready=1, expected no response outstanding", k);
          end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("latency", k, 32'(tb_cyc - e.issued), 32'(e.lat));
            chk("err", k, {31'd0, err[k]}, {31'd0, e.err});
            if (e.chk_d) chk("rd_data", k, rdata[k], e.data);
            if (e.chk_g) chk("gpio_out", k, {24'd0, gout[k]}, {24'd0, e.gpio});
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) prev_ready[k] = ready[k];
    prev_rst = rst;
  end

  task automatic issue(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] ed, input logic ee, input logic cd,
                       input logic cg, input logic [7:0] eg, input logic hold, input logic alt,
                       input logic [31:0] aa, input logic [31:0] ad, input logic cyc_rd);
    exp_t e;
    logic got;
    @(negedge clk);
    req[k] = 1'b1; addr[k] = a; wdata[k] = d; wena[k] = wr; strb[k] = s;
    e.data   = cyc_rd ? (m_cyc + ((k == 0) ? 32'd2 : 32'd1)) : ed;
    e.err    = ee;
    e.chk_d  = cd;
    e.chk_g  = cg;
    e.gpio   = eg;
    e.lat    = (k == 0) ? 3 : 2;
    e.issued = tb_cyc;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (alt && n == 0) begin
        addr[k] = aa; wdata[k] = ad; wena[k] = ~wr;
      end
      if (ready[k]) got = 1'b1;
    end
    if (!got) begin
      $display("FAIL response_timeout dut%0d: got no mem_ready within 20 cycles, expected one", k);
      $fatal(1, "no response");
    end
    if (hold) @(negedge clk);
    req[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic ee);
    issue(k, 1'b1, a, d, 4'hF, 32'd0, ee, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic rd(input int k, input logic [31:0] a, input logic [31:0] ed, input logic ee);
    issue(k, 1'b0, a, 32'd0, 4'hF, ed, ee, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0; wena[k] = 1'b0; strb[k] = 4'hF;
      prev_ready[k] = 1'b0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // Cycle counter against the reference model.
    issue(0, 1'b0, MB + 32'h8, 32'd0, 4'hF, 32'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    issue(1, 1'b0, MB + 32'h8, 32'd0, 4'hF, 32'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

    for (int k = 0; k < 2; k++) begin
      wr(k, 32'h10, 32'hDEAD_BEEF, 1'b0);
      rd(k, 32'h10, 32'hDEAD_BEEF, 1'b0);
    end

    rd(0, 32'h13, 32'd0, 1'b1);
    wr(0, 32'h0, 32'h0BAD_F00D, 1'b0);
    wr(0, 32'h1000, 32'hFFFF_FFFF, 1'b1);
    rd(0, 32'h0, 32'h0BAD_F00D, 1'b0);
    rd(0, MB + 32'h10, 32'd0, 1'b1);

    issue(0, 1'b1, MB, 32'h0000_01A5, 4'hF, 32'd0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    rd(0, MB, 32'h0000_00A5, 1'b0);
    gin = 8'h3C;
    repeat (3) @(negedge clk);
    rd(0, MB + 32'h4, 32'h0000_003C, 1'b0);
    wr(0, MB + 32'h4, 32'h0000_00FF, 1'b0);
    rd(0, MB + 32'h4, 32'h0000_003C, 1'b0);
    rd(0, MB + 32'hC, 32'd0, 1'b0);
    rd(1, MB + 32'hC, 32'd0, 1'b0);

    // Inputs changed after accept must not alter the served request.
    wr(0, 32'h44, 32'h4444_4444, 1'b0);
    issue(0, 1'b1, 32'h40, 32'h4040_4040, 4'hF, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 32'h44, 32'hBAD0_BAD0, 1'b0);
    rd(0, 32'h40, 32'h4040_4040, 1'b0);
    rd(0, 32'h44, 32'h4444_4444, 1'b0);

    // Reset during the wait state of a write aborts it.
    wr(0, 32'h20, 32'h2020_2020, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hDEAD_0020; wena[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0; req[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    rd(0, 32'h20, 32'h2020_2020, 1'b0);

    // mem_req held through the ready pulse must not start a second access.
    issue(0, 1'b0, 32'h20, 32'd0, 4'hF, 32'h2020_2020, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    rd(0, 32'h10, 32'hDEAD_BEEF, 1'b0);

`ifdef MEM_RESPONDER_BYTE_STRB_EN
    wr(0, 32'h0, 32'h1122_3344, 1'b0);
    issue(0, 1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    rd(0, 32'h0, 32'h11BB_33DD, 1'b0);
    issue(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    rd(0, 32'h0, 32'h11BB_33DD, 1'b0);
    issue(0, 1'b1, MB, 32'h0000_005A, 4'b0000, 32'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
